// File: rtl/islip_req_ctrl_if.sv
// Handshake and data bundle between the iSLIP requester/dispatcher and its
// surroundings: VOQ status in, arbiter request/result channels, and the
// per-input grant/completion lines towards the input ports.
interface islip_req_ctrl_if #(
  parameter int PORT_NUM = 4
);
  localparam int PW = $clog2(PORT_NUM);

  logic [PORT_NUM-1:0][PORT_NUM-1:0] voq_req;
  logic [PORT_NUM-1:0]               tx_rdy;
  logic                              arb_valid_out;
  logic                              arb_ready_in;
  logic [PORT_NUM-1:0][PORT_NUM-1:0] arb_req_vect;
  logic [PORT_NUM-1:0]               arb_tx_rdy;
  logic                              arb_valid_in;
  logic                              arb_ready_out;
  logic [PORT_NUM-1:0][PORT_NUM-1:0] arb_grant;
  logic [PORT_NUM-1:0]               gnt_vld;
  logic [PORT_NUM-1:0][PW-1:0]       gnt_port;
  logic [PORT_NUM-1:0]               xfer_done;
  logic                              arb_err;

  // Requester side: the controller itself.
  modport master (
    input  voq_req, tx_rdy, arb_ready_in, arb_valid_in, arb_grant, xfer_done,
    output arb_valid_out, arb_req_vect, arb_tx_rdy, arb_ready_out,
           gnt_vld, gnt_port, arb_err
  );

  // Environment side: VOQs, arbiter and input ports.
  modport slave (
    output voq_req, tx_rdy, arb_ready_in, arb_valid_in, arb_grant, xfer_done,
    input  arb_valid_out, arb_req_vect, arb_tx_rdy, arb_ready_out,
           gnt_vld, gnt_port, arb_err
  );
endinterface

// File: rtl/islip_req_ctrl.sv
// iSLIP requester/dispatcher. Builds the masked request matrix, runs one
// arbiter round (request handshake, then result handshake), validates the
// returned match matrix, dispatches legal grants and tracks busy inputs and
// outputs until each transfer reports done.
module islip_req_ctrl #(
  parameter int PORT_NUM = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             rst,
  islip_req_ctrl_if.master bus
);
  localparam int PW = $clog2(PORT_NUM);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_GNT, DISP} state_t;

  state_t                            state;
  logic                              was_disp;
  logic [CW-1:0]                     cnt;
  logic [PORT_NUM-1:0]               in_busy;
  logic [PORT_NUM-1:0]               out_busy;
  logic [PORT_NUM-1:0][PORT_NUM-1:0] grant_q;

  logic [PORT_NUM-1:0][PORT_NUM-1:0] req_mask;
  logic [PORT_NUM-1:0][PORT_NUM-1:0] others;
  logic [PORT_NUM-1:0][PW-1:0]       grant_idx;
  logic [PORT_NUM-1:0]               legal;
  logic [PORT_NUM-1:0]               illegal;
  logic [PORT_NUM-1:0]               out_set;
  logic [PORT_NUM-1:0]               done_clr;
  logic [PORT_NUM-1:0]               out_clr;

  // A granted input stays busy exactly as long as its grant is presented.
  assign bus.gnt_vld = in_busy;

  // Request matrix with busy inputs, busy outputs and stalled outputs removed.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    req_mask = '0;
    for (int n = 0; n < PORT_NUM; n++) begin
      for (int m = 0; m < PORT_NUM; m++) begin
        req_mask[n][m] = bus.voq_req[n][m] & ~in_busy[n] & ~out_busy[m] & bus.tx_rdy[m];
      end
    end
  end

  // Grant validation: one-hot, actually requested, and no output claimed twice.
  always_comb begin
    others    = '0;
    grant_idx = '0;
    legal     = '0;
    illegal   = '0;
    out_set   = '0;
    for (int n = 0; n < PORT_NUM; n++) begin
      for (int k = 0; k < PORT_NUM; k++) begin
        if (k != n) others[n] = others[n] | grant_q[k];
      end
      for (int m = 0; m < PORT_NUM; m++) begin
        if (grant_q[n][m]) grant_idx[n] = PW'(m);
      end
      if (grant_q[n] != '0) begin
        if ($onehot(grant_q[n]) &&
            ((grant_q[n] & ~bus.arb_req_vect[n]) == '0) &&
            ((grant_q[n] & others[n]) == '0)) begin
          legal[n] = 1'b1;
          out_set  = out_set | grant_q[n];
        end else begin
          illegal[n] = 1'b1;
        end
      end
    end
  end

  // Completion: a done pulse on a busy input frees that input and its output.
  always_comb begin
    done_clr = bus.xfer_done & in_busy;
    out_clr  = '0;
    for (int n = 0; n < PORT_NUM; n++) begin
      if (done_clr[n]) out_clr[bus.gnt_port[n]] = 1'b1;
    end
  end

  // Round FSM with registered handshake outputs, plus busy/grant bookkeeping.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state             <= IDLE;
      was_disp          <= 1'b0;
      cnt               <= '0;
      in_busy           <= '0;
      out_busy          <= '0;
      grant_q           <= '0;
      bus.gnt_port      <= '0;
      bus.arb_valid_out <= 1'b0;
      bus.arb_ready_out <= 1'b0;
      bus.arb_req_vect  <= '0;
      bus.arb_tx_rdy    <= '0;
      bus.arb_err       <= 1'b0;
    end else begin
      was_disp <= (state == DISP);

      // Done and dispatch touch disjoint bits, since busy resources are never requested.
      if (state == DISP) begin
        in_busy  <= (in_busy & ~done_clr) | legal;
        out_busy <= (out_busy & ~out_clr) | out_set;
        for (int n = 0; n < PORT_NUM; n++) begin
          if (legal[n]) bus.gnt_port[n] <= grant_idx[n];
        end
      end else begin
        in_busy  <= in_busy & ~done_clr;
        out_busy <= out_busy & ~out_clr;
      end

      case (state)
        IDLE: begin
          // Skipping the cycle after DISP lets the new busy masks take effect first.
          if ((req_mask != '0) && !was_disp) begin
            bus.arb_req_vect  <= req_mask;
            bus.arb_tx_rdy    <= bus.tx_rdy & ~out_busy;
            bus.arb_valid_out <= 1'b1;
            state             <= REQ;
          end
        end
        REQ: begin
          if (bus.arb_valid_out && bus.arb_ready_in) begin
            bus.arb_valid_out <= 1'b0;
            bus.arb_ready_out <= 1'b1;
            cnt               <= '0;
            state             <= WAIT_GNT;
          end
        end
        WAIT_GNT: begin
          // arb_req_vect stays frozen: the arbiter samples it a cycle after the handshake.
          if (bus.arb_valid_in) begin
            grant_q           <= bus.arb_grant;
            bus.arb_ready_out <= 1'b0;
            cnt               <= '0;
            state             <= DISP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            bus.arb_err       <= 1'b1;
            bus.arb_ready_out <= 1'b0;
            cnt               <= '0;
            state             <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DISP: begin
          if (illegal != '0) bus.arb_err <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_islip_req_ctrl.sv
// Directed bench for islip_req_ctrl. The bench plays the arbiter: it keeps
// arb_ready_in high, completes the request handshake and returns a chosen
// match matrix. Inputs are driven and outputs sampled on the falling edge.
module tb_islip_req_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic seen;

  islip_req_ctrl_if bus ();

  islip_req_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, input logic [15:0] exp_req);
    int w = 0;
    while (bus.arb_valid_out !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_valid_out"}, 32'(bus.arb_valid_out), 1);
    check({tag, "_req_vect"}, 32'(bus.arb_req_vect), 32'(exp_req));
  endtask

  task automatic wait_ready(input string tag);
    int w = 0;
    while (bus.arb_ready_out !== 1'b1 && w < 6) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_ready_out"}, 32'(bus.arb_ready_out), 1);
  endtask

  // Return a result pulse and step to the cycle after DISP.
  task automatic give(input logic [15:0] g);
    bus.arb_valid_in = 1'b1;
    bus.arb_grant    = g;
    @(negedge clk);
    bus.arb_valid_in = 1'b0;
    bus.arb_grant    = '0;
    @(negedge clk);
  endtask

  task automatic run_round(input string tag, input logic [15:0] exp_req, input logic [15:0] g);
    wait_valid(tag, exp_req);
    wait_ready(tag);
    give(g);
  endtask

  task automatic pulse_done(input logic [3:0] d);
    bus.xfer_done = d;
    @(negedge clk);
    bus.xfer_done = '0;
  endtask

  initial begin
    rst              = 1'b1;
    bus.voq_req      = '0;
    bus.tx_rdy       = '0;
    bus.arb_ready_in = 1'b1;
    bus.arb_valid_in = 1'b0;
    bus.arb_grant    = '0;
    bus.xfer_done    = '0;
    step(2);

    // Reset state
    check("rst_valid_out", 32'(bus.arb_valid_out), 0);
    check("rst_ready_out", 32'(bus.arb_ready_out), 0);
    check("rst_gnt_vld",   32'(bus.gnt_vld), 0);
    check("rst_gnt_port",  32'(bus.gnt_port), 0);
    check("rst_req_vect",  32'(bus.arb_req_vect), 0);
    check("rst_tx_rdy",    32'(bus.arb_tx_rdy), 0);
    check("rst_err",       32'(bus.arb_err), 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: permutation 0->1, 1->0, 2->3, 3->2
    bus.tx_rdy  = 4'hF;
    bus.voq_req = 16'h4812;
    run_round("t1", 16'h4812, 16'h4812);
    bus.voq_req = '0;
    check("t1_gnt_vld",  32'(bus.gnt_vld), 32'hF);
    check("t1_gnt_port", 32'(bus.gnt_port), 32'hB1);
    check("t1_tx_rdy",   32'(bus.arb_tx_rdy), 32'hF);
    check("t1_err",      32'(bus.arb_err), 0);
    pulse_done(4'hF);
    check("t1_done_gnt_vld", 32'(bus.gnt_vld), 0);

    // 3: no output ready, all VOQs full
    bus.tx_rdy  = 4'h0;
    bus.voq_req = 16'hFFFF;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen = seen | bus.arb_valid_out;
    end
    check("t3_valid_seen", 32'(seen), 0);
    check("t3_ready_out",  32'(bus.arb_ready_out), 0);

    // 2: every input wants output 2
    bus.tx_rdy  = 4'hF;
    bus.voq_req = 16'h4444;
    run_round("t2a", 16'h4444, 16'h0004);
    check("t2a_gnt_vld",  32'(bus.gnt_vld), 32'h1);
    check("t2a_gnt_port", 32'(bus.gnt_port[0]), 2);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen = seen | bus.arb_valid_out;
    end
    check("t2_masked_valid_seen", 32'(seen), 0);
    pulse_done(4'h1);
    run_round("t2b", 16'h4444, 16'h0040);
    check("t2b_gnt_vld",  32'(bus.gnt_vld), 32'h2);
    check("t2b_gnt_port", 32'(bus.gnt_port[1]), 2);
    bus.voq_req = '0;
    pulse_done(4'h2);
    @(negedge clk);

    // 5: input 1 gets a two-hot grant, inputs 0 and 2 legal
    bus.voq_req = 16'h0852;
    run_round("t5", 16'h0852, 16'h0852);
    bus.voq_req = '0;
    check("t5_gnt_vld",   32'(bus.gnt_vld), 32'h5);
    check("t5_gnt_port0", 32'(bus.gnt_port[0]), 1);
    check("t5_gnt_port2", 32'(bus.gnt_port[2]), 3);
    check("t5_err",       32'(bus.arb_err), 1);
    pulse_done(4'h5);

    // Clear the sticky error before the timeout case
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst2_err", 32'(bus.arb_err), 0);

    // 4: arbiter never answers
    bus.voq_req = 16'h0001;
    wait_valid("t4", 16'h0001);
    wait_ready("t4");
    bus.voq_req = '0;
    step(15);
    check("t4_err_before",   32'(bus.arb_err), 0);
    check("t4_ready_before", 32'(bus.arb_ready_out), 1);
    step(1);
    check("t4_err",       32'(bus.arb_err), 1);
    check("t4_ready_out", 32'(bus.arb_ready_out), 0);
    check("t4_gnt_vld",   32'(bus.gnt_vld), 0);
    step(1);
    check("t4_idle_valid", 32'(bus.arb_valid_out), 0);

    // 6: reset while waiting for a grant with input 0 busy
    bus.voq_req = 16'h0001;
    run_round("t6a", 16'h0001, 16'h0001);
    check("t6a_gnt_vld", 32'(bus.gnt_vld), 32'h1);
    bus.voq_req = 16'h0021;
    wait_valid("t6m", 16'h0020);
    check("t6m_tx_rdy", 32'(bus.arb_tx_rdy), 32'hE);
    wait_ready("t6m");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_gnt_vld",   32'(bus.gnt_vld), 0);
    check("t6_valid_out", 32'(bus.arb_valid_out), 0);
    check("t6_ready_out", 32'(bus.arb_ready_out), 0);
    check("t6_req_vect",  32'(bus.arb_req_vect), 0);
    check("t6_tx_rdy",    32'(bus.arb_tx_rdy), 0);
    check("t6_gnt_port",  32'(bus.gnt_port), 0);
    check("t6_err",       32'(bus.arb_err), 0);
    run_round("t6b", 16'h0021, 16'h0021);
    check("t6b_gnt_vld",  32'(bus.gnt_vld), 32'h3);
    check("t6b_gnt_port", 32'(bus.gnt_port), 32'h04);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
